i2c_target_tx: RTL and testbench

- Read-direction data path of the I2C target.
- After the target core ACKs an address with R/W=1, this block serves register bytes to the controller, MSB first, on SDA.
- Register address auto-increments while the controller ACKs each byte; a NACK or STOP ends the transfer.
- Sits beside i2c_target: target core handles address match and write path; this block owns SDA only during read data phases.

---
 rtl/i2c_target_tx.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_target_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_tx.sv
// Read-direction data path of the I2C target: serves register bytes MSB first on SDA.
// The optional SCL-low timeout abort is compiled in with `define I2C_TX_TIMEOUT_EN.
module i2c_target_tx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [7:0]  REG_LAST       = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic       start_i,
  input  logic [7:0] start_addr_i,
  input  logic       stop_i,
  output logic [7:0] reg_addr_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_data_i,
  output logic       busy_o,
  output logic       byte_done_o,
  output logic       nack_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    LOAD       = 3'd2,
    SHIFT      = 3'd3,
    ACK_WAIT   = 3'd4,
    ACK_SAMPLE = 3'd5
  } state_t;

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  state_t            state, state_d;
  logic [SYNC_N-1:0] scl_sync, sda_sync;
  logic              scl_prev, scl_s, sda_s, scl_fall, scl_rise;
  logic [7:0]        shift, shift_d, addr_d;
  logic [3:0]        bit_cnt, cnt_d;
  logic              ack_bit, ack_d;
  logic              oe_d, rd_d, done_d, nack_d, tmo_d, to_hit;

  // Pad synchronisers; reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= {SYNC_N{1'b1}};
      sda_sync <= {SYNC_N{1'b1}};
      scl_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_N-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_N-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_N-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_N-1];
  assign sda_s    = sda_sync[SYNC_N-1];
  assign scl_fall = scl_prev & ~scl_s;
  assign scl_rise = ~scl_prev & scl_s;
  assign busy_o   = (state != IDLE);

`ifdef I2C_TX_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] to_cnt;

  assign to_hit = busy_o & ~scl_s & (to_cnt == TO_LIMIT);

  // SCL-low watchdog: counts only while busy with SCL low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt <= 16'd0;
    end else if (busy_o && !scl_s && !to_hit) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= 16'd0;
    end
  end
`else
  // No watchdog: the block waits indefinitely for SCL.
  assign to_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    addr_d  = reg_addr_o;
    shift_d = shift;
    cnt_d   = bit_cnt;
    ack_d   = ack_bit;
    oe_d    = sda_oe_o;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    nack_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state)
      IDLE: begin
        oe_d = 1'b0;
        if (start_i) begin
          addr_d  = start_addr_i;
          rd_d    = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        shift_d = reg_data_i;
        state_d = LOAD;
      end
      LOAD: begin
        oe_d    = ~shift[7];
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd8;
            state_d = ACK_WAIT;
          end else begin
            cnt_d   = bit_cnt + 4'd1;
            shift_d = {shift[6:0], 1'b0};
            oe_d    = ~shift[6];
          end
        end else begin
          state_d = SHIFT;
        end
      end
      ACK_WAIT: begin
        if (scl_rise) begin
          ack_d   = sda_s;
          done_d  = 1'b1;
          state_d = ACK_SAMPLE;
        end else begin
          state_d = ACK_WAIT;
        end
      end
      ACK_SAMPLE: begin
        // bit_cnt still at 8 marks the address increment as pending.
        if (ack_bit) begin
          nack_d  = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end else if (bit_cnt == 4'd8) begin
          addr_d = (reg_addr_o == REG_LAST) ? 8'h00 : reg_addr_o + 8'd1;
          rd_d   = 1'b1;
          cnt_d  = 4'd0;
        end else if (scl_fall) begin
          state_d = FETCH;
        end else begin
          state_d = ACK_SAMPLE;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (busy_o && stop_i) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      rd_d    = 1'b0;
      done_d  = 1'b0;
      nack_d  = 1'b0;
    end else if (to_hit) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      rd_d    = 1'b0;
      done_d  = 1'b0;
      nack_d  = 1'b0;
      tmo_d   = 1'b1;
    end else begin
      tmo_d = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      shift       <= 8'h00;
      bit_cnt     <= 4'd0;
      ack_bit     <= 1'b0;
      sda_oe_o    <= 1'b0;
      reg_addr_o  <= 8'h00;
      reg_rd_o    <= 1'b0;
      byte_done_o <= 1'b0;
      nack_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_d;
      shift       <= shift_d;
      bit_cnt     <= cnt_d;
      ack_bit     <= ack_d;
      sda_oe_o    <= oe_d;
      reg_addr_o  <= addr_d;
      reg_rd_o    <= rd_d;
      byte_done_o <= done_d;
      nack_o      <= nack_d;
      timeout_o   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_i2c_target_tx.sv
// Self-checking bench for i2c_target_tx: a bus-level controller model reads bytes and
// compares them with a register-map model; define I2C_TX_TIMEOUT_EN to cover the watchdog.
module tb_i2c_target_tx;
  localparam logic [7:0] REG_LAST = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_ni, scl, ctrl_sda, start, stop;
  logic [7:0] start_addr, reg_addr, reg_data;
  logic       sda_oe, reg_rd, busy, byte_done, nack, timeout, sda_line;
  logic [7:0] mem [256];
  logic [7:0] rd_log [$];
  int         n_cmp = 0, n_fail = 0;
  int         rd_cnt = 0, done_cnt = 0, nack_cnt = 0, tmo_cnt = 0;

  always #5 clk = ~clk;

  assign reg_data = mem[reg_addr];
  assign sda_line = ctrl_sda & ~sda_oe;

  i2c_target_tx #(.SYNC_STAGES(2), .REG_LAST(REG_LAST), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .scl_i(scl), .sda_i(sda_line), .sda_oe_o(sda_oe),
    .start_i(start), .start_addr_i(start_addr), .stop_i(stop), .reg_addr_o(reg_addr),
    .reg_rd_o(reg_rd), .reg_data_i(reg_data), .busy_o(busy), .byte_done_o(byte_done),
    .nack_o(nack), .timeout_o(timeout)
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (reg_rd) begin
        rd_cnt++;
        rd_log.push_back(reg_addr);
      end
      if (byte_done) done_cnt++;
      if (nack) nack_cnt++;
      if (timeout) tmo_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] model_addr(input logic [7:0] base, input int k);
    int span = int'(REG_LAST) + 1;
    return 8'((int'(base) + k) % span);
  endfunction

  task automatic clock_bit(output logic b, output bit unstable);
    int lo = $urandom_range(14, 10);
    int hi = $urandom_range(8, 4);
    unstable = 1'b0;
    repeat (lo) @(negedge clk);
    b   = sda_line;
    scl = 1'b1;
    repeat (hi) begin
      @(negedge clk);
      if (sda_line !== b) unstable = 1'b1;
    end
    scl = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b, output bit unstable);
    logic bit_v;
    bit   u;
    unstable = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(bit_v, u);
      b[i] = bit_v;
      if (u) unstable = 1'b1;
    end
  endtask

  task automatic ack_phase(input bit ack, output logic released);
    int lo = $urandom_range(14, 10);
    int hi = $urandom_range(8, 4);
    ctrl_sda = ~ack;
    repeat (lo) @(negedge clk);
    released = ~sda_oe;
    scl = 1'b1;
    repeat (hi) @(negedge clk);
    scl = 1'b0;
    @(negedge clk);
    ctrl_sda = 1'b1;
  endtask

  task automatic begin_transfer(input logic [7:0] addr, input bit with_stop);
    scl = 1'b0;
    repeat (2) @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    stop       = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run_transfer(input logic [7:0] addr, input int n, input bit dup_start,
                              input bit with_stop, input string tag);
    int         d0 = done_cnt, n0 = nack_cnt;
    logic [7:0] got, exp;
    bit         unst;
    logic       rel;
    rd_log.delete();
    begin_transfer(addr, with_stop);
    if (dup_start) begin
      start      = 1'b1;
      start_addr = ~addr;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      read_byte(got, unst);
      exp = mem[model_addr(addr, k)];
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s byte%0d: got %h expected %h", tag, k, got, exp);
      end
      n_cmp++;
      if (unst) begin
        n_fail++;
        $display("FAIL %s sda_stable byte%0d: SDA changed while SCL high, expected stable", tag, k);
      end
      ack_phase(k != n - 1, rel);
      n_cmp++;
      if (rel !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ack_release byte%0d: released=%b expected 1", tag, k, rel);
      end
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_idle: busy=%b sda_oe=%b expected 0/0", tag, busy, sda_oe);
    end
    n_cmp++;
    if (nack_cnt - n0 != 1 || done_cnt - d0 != n) begin
      n_fail++;
      $display("FAIL %s pulses: nack=%0d byte_done=%0d expected 1/%0d", tag, nack_cnt - n0,
               done_cnt - d0, n);
    end
    n_cmp++;
    if (rd_log.size() != n) begin
      n_fail++;
      $display("FAIL %s rd_count: got %0d expected %0d", tag, rd_log.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (rd_log[k] !== model_addr(addr, k)) begin
          n_fail++;
          $display("FAIL %s rd_addr%0d: got %h expected %h", tag, k, rd_log[k], model_addr(addr, k));
        end
      end
    end
    n_cmp++;
    if (reg_addr !== model_addr(addr, n - 1)) begin
      n_fail++;
      $display("FAIL %s reg_addr_hold: got %h expected %h", tag, reg_addr, model_addr(addr, n - 1));
    end
    scl = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; scl = 1'b1; ctrl_sda = 1'b1; start = 1'b0; stop = 1'b0; start_addr = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sda_oe, reg_addr, reg_rd, busy, byte_done, nack, timeout} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: oe=%b addr=%h rd=%b busy=%b done=%b nack=%b tmo=%b expected all 0",
               sda_oe, reg_addr, reg_rd, busy, byte_done, nack, timeout);
    end
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b sda_oe=%b expected 0/0", busy, sda_oe);
    end
  endtask

  task automatic test_single_byte;
    mem[8'h06] = 8'hA5;
    run_transfer(8'h06, 1, 1'b0, 1'b0, "single");
  endtask

  task automatic test_auto_increment;
    for (int a = 6; a <= 8; a++) mem[a] = 8'(a + 8'h10);
    run_transfer(8'h06, 3, 1'b0, 1'b0, "autoinc");
  endtask

  task automatic test_wrap;
    run_transfer(REG_LAST, 2, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) run_transfer(8'($urandom), $urandom_range(4, 1), 1'b0, 1'b0, "random");
  endtask

  task automatic test_back_to_back;
    run_transfer(8'($urandom), 2, 1'b1, 1'b1, "start_busy");
    run_transfer(8'($urandom), 1, 1'b0, 1'b0, "b2b");
  endtask

  task automatic test_stop_mid_byte;
    logic [7:0] addr = 8'($urandom);
    logic [3:0] hi_bits;
    int         d0, n0;
    bit         u;
    logic       b;
    mem[addr] = 8'($urandom) & 8'hF7;
    d0 = done_cnt; n0 = nack_cnt;
    begin_transfer(addr, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      clock_bit(b, u);
      hi_bits[i] = b;
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (hi_bits !== mem[addr][7:4] || sda_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_pre: bits=%h oe=%b expected %h/1", hi_bits, sda_oe, mem[addr][7:4]);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_release: oe=%b busy=%b expected 0/0", sda_oe, busy);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || nack_cnt != n0) begin
      n_fail++;
      $display("FAIL stop_pulses: byte_done=%0d nack=%0d expected 0/0", done_cnt - d0, nack_cnt - n0);
    end
    scl = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout;
    logic [7:0] addr = 8'($urandom);
    int         t0 = tmo_cnt, first = -1;
    bit         u;
    logic       b;
    begin_transfer(addr, 1'b0);
    for (int i = 0; i < 3; i++) clock_bit(b, u);
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (timeout === 1'b1 && first < 0) first = c;
    end
`ifdef I2C_TX_TIMEOUT_EN
    n_cmp++;
    if (first < 100 || first > 105 || tmo_cnt - t0 != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: at cycle %0d count %0d expected ~100 and 1", first, tmo_cnt - t0);
    end
    n_cmp++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b oe=%b expected 0/0", busy, sda_oe);
    end
`else
    n_cmp++;
    if (first != -1 || tmo_cnt != t0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout: pulse_cycle=%0d busy=%b expected none/1", first, busy);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
`endif
    scl = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0] addr = 8'($urandom);
    mem[addr] = 8'($urandom) & 8'h7F;
    begin_transfer(addr, 1'b0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (sda_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: oe=%b expected 1", sda_oe);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({sda_oe, reg_addr, reg_rd, busy, byte_done, nack, timeout} !== 14'd0) begin
      n_fail++;
      $display("FAIL rst_async: oe=%b addr=%h rd=%b busy=%b expected all 0", sda_oe, reg_addr,
               reg_rd, busy);
    end
    @(negedge clk);
    scl = 1'b1;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset;
    test_single_byte;
    test_auto_increment;
    test_wrap;
    test_random;
    test_back_to_back;
    test_stop_mid_byte;
    test_timeout;
    test_reset_mid_byte;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
